// File: rtl/polymul_rom6_sequencer.sv
// Stage-6 ROM walker: fetches 128 packed words and issues basemul ops.
// Optional macro ROM6_SEQ_PERF_EN adds perf_cycles / perf_stalls counters.
module polymul_rom6_sequencer #(
  parameter int N_ENTRIES  = 128,
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        srst,
  input  logic        start,
  input  logic        abort,
  output logic [6:0]  rom_addr,
  input  logic [63:0] rom_dout,
  output logic        op_valid,
  input  logic        op_ready,
  output logic [11:0] op_scale,
  output logic [7:0]  op_addr_a,
  output logic [7:0]  op_addr_b,
  output logic [11:0] op_zeta,
  output logic [7:0]  op_addr_c,
  output logic [7:0]  op_addr_d,
  output logic [6:0]  op_index,
  output logic        op_last,
  output logic        busy,
  output logic        done
`ifdef ROM6_SEQ_PERF_EN
  ,
  output logic [15:0] perf_cycles,
  output logic [15:0] perf_stalls
`endif
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  typedef struct packed {
    logic [11:0] scale;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [11:0] zeta;
    logic [7:0]  c;
    logic [7:0]  d;
    logic [6:0]  idx;
  } entry_t;

  state_t          state_q;
  state_t          state_d;
  entry_t          mem [FIFO_DEPTH];
  entry_t          head;
  entry_t          entry_in;
  logic [PW-1:0]   rd_q;
  logic [PW-1:0]   wr_q;
  logic [CW-1:0]   occ_q;
  logic [7:0]      cnt_q;
  logic [6:0]      hold_q;
  logic            infl_q;
  logic [6:0]      infl_idx_q;
  logic            done_q;
  logic            pop;
  logic            push;
  logic            last_hs;
  logic            cnt_end;
  logic            fetch;
  logic            start_ok;
  logic [31:0]     used;
  logic [31:0]     room;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Handshake, credit and fetch decisions
  always_comb begin
    head     = mem[rd_q];
    op_valid = (occ_q != '0);
    pop      = op_valid & op_ready;
    push     = infl_q & ~abort;
    op_last  = op_valid & (head.idx == 7'(N_ENTRIES - 1));
    last_hs  = pop & op_last;
    cnt_end  = (cnt_q >= 8'(N_ENTRIES));
    used     = 32'(occ_q) + 32'(infl_q);
    room     = 32'(FIFO_DEPTH) + 32'(pop);
    start_ok = (state_q == IDLE) & start & ~abort;
    fetch    = (state_q == RUN) & ~abort & ~cnt_end & (used < room);
    entry_in = '{
      scale: rom_dout[59:48],
      a:     rom_dout[47:40],
      b:     rom_dout[39:32],
      zeta:  rom_dout[27:16],
      c:     rom_dout[15:8],
      d:     rom_dout[7:0],
      idx:   infl_idx_q
    };
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_ok) state_d = RUN;
      RUN: begin
        if (abort || last_hs) state_d = IDLE;
        else if (cnt_end)     state_d = DRAIN;
      end
      DRAIN:   if (abort || last_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, fetch counter and in-flight tracking
  always_ff @(posedge clk) begin
    if (srst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      hold_q     <= '0;
      infl_q     <= 1'b0;
      infl_idx_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= last_hs & ~abort & (state_q != IDLE);
      infl_q  <= fetch;
      if (fetch) begin
        infl_idx_q <= cnt_q[6:0];
        hold_q     <= cnt_q[6:0];
        cnt_q      <= cnt_q + 8'd1;
      end
      if (start_ok) cnt_q <= '0;
    end
  end

  // Output skid FIFO; abort flushes it without clearing storage
  always_ff @(posedge clk) begin
    if (srst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      occ_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else if (abort) begin
      rd_q  <= '0;
      wr_q  <= '0;
      occ_q <= '0;
    end else begin
      if (push) begin
        mem[wr_q] <= entry_in;
        wr_q      <= nxt(wr_q);
      end
      if (pop) rd_q <= nxt(rd_q);
      occ_q <= occ_q + CW'(push) - CW'(pop);
    end
  end

  // Output mapping from FIFO head and control state
  always_comb begin
    rom_addr  = ((state_q == RUN) && !cnt_end) ? cnt_q[6:0] : hold_q;
    op_scale  = head.scale;
    op_addr_a = head.a;
    op_addr_b = head.b;
    op_zeta   = head.zeta;
    op_addr_c = head.c;
    op_addr_d = head.d;
    op_index  = head.idx;
    busy      = (state_q != IDLE);
    done      = done_q;
  end

`ifdef ROM6_SEQ_PERF_EN
  // Saturating busy-cycle and stall counters, cleared on accepted start
  always_ff @(posedge clk) begin
    if (srst) begin
      perf_cycles <= '0;
      perf_stalls <= '0;
    end else if (start_ok) begin
      perf_cycles <= '0;
      perf_stalls <= '0;
    end else begin
      if (busy && perf_cycles != 16'hFFFF)
        perf_cycles <= perf_cycles + 16'd1;
      if (op_valid && !op_ready && perf_stalls != 16'hFFFF)
        perf_stalls <= perf_stalls + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_polymul_rom6_sequencer.sv
// Bench for polymul_rom6_sequencer with a registered ROM model.
// Expected ops come from field tables built by the bench itself.
`timescale 1ns/1ps
module tb_polymul_rom6_sequencer;

  logic        clk = 1'b0;
  logic        srst;
  logic        start;
  logic        abort;
  logic [6:0]  rom_addr;
  logic [63:0] rom_dout = '0;
  logic        op_valid;
  logic        op_ready;
  logic [11:0] op_scale;
  logic [7:0]  op_addr_a;
  logic [7:0]  op_addr_b;
  logic [11:0] op_zeta;
  logic [7:0]  op_addr_c;
  logic [7:0]  op_addr_d;
  logic [6:0]  op_index;
  logic        op_last;
  logic        busy;
  logic        done;
`ifdef ROM6_SEQ_PERF_EN
  logic [15:0] perf_cycles;
  logic [15:0] perf_stalls;
`endif

  typedef struct packed {
    logic [11:0] scale;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [11:0] zeta;
    logic [7:0]  c;
    logic [7:0]  d;
    logic [6:0]  idx;
  } op_t;

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] rom [128];
  logic [11:0] scale_tab [128];
  int zetas [64] = '{
    2226, 430, 555, 843, 2078, 871, 1550, 105,
    422, 587, 177, 3094, 3038, 2869, 1574, 1653,
    3083, 778, 1159, 3182, 2552, 1483, 2727, 1119,
    1739, 644, 2457, 349, 418, 329, 3173, 3254,
    817, 1097, 603, 610, 1322, 2044, 1864, 384,
    2114, 3193, 1218, 1994, 2455, 220, 2142, 1670,
    2144, 1799, 2051, 794, 1819, 2475, 2459, 478,
    3221, 3021, 996, 991, 958, 1869, 1522, 1628
  };
  op_t obs;

  assign obs = {op_scale, op_addr_a, op_addr_b, op_zeta,
                op_addr_c, op_addr_d, op_index};

  always #5 clk = ~clk;

  always @(posedge clk) rom_dout <= rom[rom_addr];

  polymul_rom6_sequencer dut (
    .clk(clk), .srst(srst), .start(start), .abort(abort),
    .rom_addr(rom_addr), .rom_dout(rom_dout),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_scale(op_scale), .op_addr_a(op_addr_a),
    .op_addr_b(op_addr_b), .op_zeta(op_zeta),
    .op_addr_c(op_addr_c), .op_addr_d(op_addr_d),
    .op_index(op_index), .op_last(op_last),
    .busy(busy), .done(done)
`ifdef ROM6_SEQ_PERF_EN
    , .perf_cycles(perf_cycles), .perf_stalls(perf_stalls)
`endif
  );

  // Basemul pair i: zeta shared by pairs, c/d interleaved by 4
  function automatic op_t exp_op(input int i);
    op_t e;
    e.scale = scale_tab[i];
    e.a     = 8'(i);
    e.b     = 8'(i + 128);
    e.zeta  = 12'(zetas[i / 2]);
    e.c     = 8'(4 * (i / 2) + i % 2);
    e.d     = 8'(4 * (i / 2) + i % 2 + 2);
    e.idx   = 7'(i);
    return e;
  endfunction

  task automatic build_rom();
    op_t e;
    for (int i = 0; i < 128; i++) begin
      scale_tab[i] = (i == 0) ? 12'h2f6 : 12'($urandom);
      e = exp_op(i);
      rom[i] = {4'($urandom), e.scale, e.a, e.b,
                4'($urandom), e.zeta, e.c, e.d};
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    srst = 1'b1; start = 1'b0; abort = 1'b0; op_ready = 1'b0;
    repeat (3) cyc();
    n_cmp++;
    if ({op_valid, busy, done, op_last} !== 4'b0) begin
      n_bad++;
      $display("FAIL reset_flags got=%b want=0000",
               {op_valid, busy, done, op_last});
    end
    n_cmp++;
    if (rom_addr !== 7'd0) begin
      n_bad++;
      $display("FAIL reset_rom_addr got=%h want=0", rom_addr);
    end
    n_cmp++;
    if (obs !== '0) begin
      n_bad++;
      $display("FAIL reset_fields got=%h want=0", obs);
    end
    srst = 1'b0;
    cyc();
    n_cmp++;
    if (busy !== 1'b0 || op_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_idle busy=%b valid=%b want 0", busy, op_valid);
    end
  endtask

  task automatic test_full_run();
    op_ready = 1'b1;
    start = 1'b1; cyc(); start = 1'b0;
    for (int c = 1; c <= 134; c++) begin
      n_cmp++;
      if (busy !== (c <= 130)) begin
        n_bad++;
        $display("FAIL full_busy c=%0d got=%b want=%b", c, busy, c <= 130);
      end
      n_cmp++;
      if (done !== (c == 131)) begin
        n_bad++;
        $display("FAIL full_done c=%0d got=%b want=%b", c, done, c == 131);
      end
      n_cmp++;
      if (op_valid !== (c >= 3 && c <= 130)) begin
        n_bad++;
        $display("FAIL full_valid c=%0d got=%b", c, op_valid);
      end
      if (c >= 3 && c <= 130) begin
        n_cmp++;
        if (obs !== exp_op(c - 3)) begin
          n_bad++;
          $display("FAIL full_op c=%0d got=%h want=%h", c, obs, exp_op(c - 3));
        end
        n_cmp++;
        if (op_last !== (c == 130)) begin
          n_bad++;
          $display("FAIL full_last c=%0d got=%b", c, op_last);
        end
      end
      if (c == 1) begin
        n_cmp++;
        if (rom_addr !== 7'd0) begin
          n_bad++;
          $display("FAIL full_addr0 got=%h want=0", rom_addr);
        end
      end
      if (c == 3) begin
        n_cmp++;
        if ({op_scale, op_zeta, op_addr_b, op_addr_d} !==
            {12'h2f6, 12'h8b2, 8'h80, 8'h02}) begin
          n_bad++;
          $display("FAIL full_op0 got=%h %h %h %h want=2f6 8b2 80 02",
                   op_scale, op_zeta, op_addr_b, op_addr_d);
        end
      end
      if (c == 130) begin
        n_cmp++;
        if ({op_zeta, op_addr_a, op_addr_b, op_addr_c, op_addr_d} !==
            {12'h65c, 8'h7f, 8'hff, 8'hfd, 8'hff}) begin
          n_bad++;
          $display("FAIL full_op127 got=%h %h %h %h %h", op_zeta,
                   op_addr_a, op_addr_b, op_addr_c, op_addr_d);
        end
      end
      cyc();
    end
  endtask

  task automatic test_backpressure(input bit rnd);
    int   n = 0;
    int   dones = 0;
    bit   fin = 0;
    bit   stalled = 0;
    op_t  held = '0;
    start = 1'b1; cyc(); start = 1'b0;
    for (int c = 1; c < 2000 && !fin; c++) begin
      if (stalled) begin
        n_cmp++;
        if (op_valid !== 1'b1 || obs !== held) begin
          n_bad++;
          $display("FAIL bp_hold c=%0d got=%h want=%h", c, obs, held);
        end
      end
      if (done) begin
        dones++;
        fin = 1;
      end
      if (rnd) op_ready = 1'($urandom);
      else     op_ready = ((c - 1) % 4 == 0) || ((c - 1) % 4 == 3);
      if (op_valid && !op_ready && op_index == 7'd5) begin
        n_cmp++;
        if ({op_zeta, op_addr_c, op_addr_d} !== {12'h22b, 8'h09, 8'h0b}) begin
          n_bad++;
          $display("FAIL bp_op5 got=%h %h %h want=22b 09 0b",
                   op_zeta, op_addr_c, op_addr_d);
        end
      end
      if (op_valid && op_ready) begin
        n_cmp++;
        if (n > 127 || obs !== exp_op(n)) begin
          n_bad++;
          $display("FAIL bp_op n=%0d got=%h want=%h", n, obs, exp_op(n));
        end
        n++;
      end
      stalled = op_valid && !op_ready;
      held = obs;
      cyc();
    end
    n_cmp++;
    if (!fin || n != 128) begin
      n_bad++;
      $display("FAIL bp_count done=%0b got=%0d want=128", fin, n);
    end
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if ({done, busy, op_valid} !== 3'b0) begin
        n_bad++;
        $display("FAIL bp_after got=%b want=000", {done, busy, op_valid});
      end
      cyc();
    end
  endtask

  task automatic test_start_ignored();
    int n = 0;
    int dones = 0;
    op_ready = 1'b1;
    start = 1'b1; cyc(); start = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      if (done) begin
        dones++;
        n_cmp++;
        if (c != 131) begin
          n_bad++;
          $display("FAIL ign_done_time got=%0d want=131", c);
        end
      end
      if (op_valid && op_ready) begin
        n_cmp++;
        if (n > 127 || obs !== exp_op(n)) begin
          n_bad++;
          $display("FAIL ign_op n=%0d got=%h want=%h", n, obs, exp_op(n));
        end
        n++;
      end
      start = (c == 20 || c == 60 || c == 100);
      cyc();
    end
    start = 1'b0;
    n_cmp++;
    if (n != 128 || dones != 1) begin
      n_bad++;
      $display("FAIL ign_count hs=%0d dones=%0d want 128 1", n, dones);
    end
  endtask

  task automatic test_abort();
    bit found = 0;
    int n = 0;
    int dones = 0;
    op_ready = 1'b1;
    start = 1'b1; cyc(); start = 1'b0;
    for (int c = 1; c < 300 && !found; c++) begin
      if (op_valid && op_index == 7'h40) begin
        found = 1;
        abort = 1'b1;
      end
      cyc();
    end
    abort = 1'b0;
    n_cmp++;
    if (!found || op_valid !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_next found=%0b valid=%b busy=%b want 1 0 0",
               found, op_valid, busy);
    end
    for (int k = 0; k < 8; k++) begin
      n_cmp++;
      if ({done, busy, op_valid} !== 3'b0) begin
        n_bad++;
        $display("FAIL abort_quiet got=%b want=000", {done, busy, op_valid});
      end
      cyc();
    end
    start = 1'b1; abort = 1'b1; cyc(); start = 1'b0; abort = 1'b0;
    cyc();
    n_cmp++;
    if (busy !== 1'b0 || op_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_wins busy=%b valid=%b want 0 0", busy, op_valid);
    end
    start = 1'b1; cyc(); start = 1'b0;
    for (int c = 1; c <= 134; c++) begin
      if (c == 3) begin
        n_cmp++;
        if (op_valid !== 1'b1 || op_index !== 7'd0 || op_zeta !== 12'h8b2) begin
          n_bad++;
          $display("FAIL abort_restart valid=%b idx=%h zeta=%h want 1 00 8b2",
                   op_valid, op_index, op_zeta);
        end
      end
      if (done) dones++;
      if (op_valid && op_ready) begin
        n_cmp++;
        if (n > 127 || obs !== exp_op(n)) begin
          n_bad++;
          $display("FAIL abort_op n=%0d got=%h want=%h", n, obs, exp_op(n));
        end
        n++;
      end
      cyc();
    end
    n_cmp++;
    if (n != 128 || dones != 1) begin
      n_bad++;
      $display("FAIL abort_rerun hs=%0d dones=%0d want 128 1", n, dones);
    end
  endtask

  task automatic test_srst_midrun();
    int n = 0;
    int dones = 0;
    start = 1'b1; cyc(); start = 1'b0;
    for (int c = 1; c < 50; c++) begin
      op_ready = 1'($urandom);
      cyc();
    end
    srst = 1'b1;
    cyc();
    n_cmp++;
    if ({op_valid, busy, done, op_last} !== 4'b0 || rom_addr !== 7'd0 ||
        obs !== '0) begin
      n_bad++;
      $display("FAIL srst_out flags=%b addr=%h fields=%h want 0",
               {op_valid, busy, done, op_last}, rom_addr, obs);
    end
    srst = 1'b0;
    op_ready = 1'b1;
    cyc();
    start = 1'b1; cyc(); start = 1'b0;
    for (int c = 1; c <= 134; c++) begin
      if (done) begin
        dones++;
        n_cmp++;
        if (c != 131) begin
          n_bad++;
          $display("FAIL srst_done_time got=%0d want=131", c);
        end
      end
      if (op_valid && op_ready) begin
        n_cmp++;
        if (n > 127 || obs !== exp_op(n) || c != n + 3) begin
          n_bad++;
          $display("FAIL srst_op n=%0d c=%0d got=%h want=%h",
                   n, c, obs, exp_op(n));
        end
        n++;
      end
      cyc();
    end
    n_cmp++;
    if (n != 128 || dones != 1) begin
      n_bad++;
      $display("FAIL srst_rerun hs=%0d dones=%0d want 128 1", n, dones);
    end
  endtask

`ifdef ROM6_SEQ_PERF_EN
  task automatic test_perf();
    bit seen = 0;
    bit fin = 0;
    int k = 0;
    op_ready = 1'b0;
    start = 1'b1; cyc(); start = 1'b0;
    for (int c = 1; c < 400 && !fin; c++) begin
      if (done) fin = 1;
      if (op_valid) seen = 1;
      if (seen) begin
        op_ready = (k >= 10);
        if (k < 10) k++;
      end else begin
        op_ready = 1'b0;
      end
      cyc();
    end
    repeat (3) cyc();
    n_cmp++;
    if (!fin || perf_cycles !== 16'd140 || perf_stalls !== 16'd10) begin
      n_bad++;
      $display("FAIL perf done=%0b cycles=%0d stalls=%0d want 140 10",
               fin, perf_cycles, perf_stalls);
    end
  endtask
`endif

  initial begin
    srst = 1'b1; start = 1'b0; abort = 1'b0; op_ready = 1'b0;
    build_rom();
    test_reset();
    test_full_run();
    test_backpressure(1'b0);
    test_backpressure(1'b1);
    test_start_ignored();
    test_abort();
    test_srst_midrun();
`ifdef ROM6_SEQ_PERF_EN
    test_perf();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
